entry_rx: RTL and testbench

- Bit-timing front end of the DRSSTC controller's serial command input.
- Synchronises the asynchronous serial line `data_raw` into the `clk` domain and detects a start bit (falling edge).
- Then runs a 4-state UART-style frame sequencer: start, DATA_BITS data bits, stop.
- Exposes the synchronised line, FSM state, bit-period timer, a bit-rate clock and a mid-bit sample strobe, for a downstream shift register or decoder.

---
 rtl/entry_pkg.sv | 17 +
 rtl/entry_rx_sync2.sv | 31 +++
 rtl/entry_rx.sv | 153 +++++++++++++++
 tb/tb_entry_rx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/entry_pkg.sv
// Shared definitions for the serial command receiver front end.
//   state_t : frame sequencer state encoding (2 bits)
//   TMR_W   : width of the bit-period tick counter
//   BCNT_W  : width of the data-bit counter (holds 0..16)
package entry_pkg;

  localparam int TMR_W  = 6;
  localparam int BCNT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/entry_rx_sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
//   clk : destination clock, rising edge
//   rst : asynchronous active-high reset, loads RST_VAL into both flops
//   d   : asynchronous input
//   q   : synchronised output, two clk edges after d
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_r;
  logic s2_r;

  // Two-stage metastability filter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= RST_VAL;
      s2_r <= RST_VAL;
    end else begin
      s1_r <= d;
      s2_r <= s1_r;
    end
  end

  assign q = s2_r;

endmodule

// File: rtl/entry_rx.sv
// Bit-timing front end of the serial command input. Synchronises the line,
// detects a start edge and sequences a start / DATA_BITS data / stop frame.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   data_raw   : asynchronous serial line (idle 1, start bit 0)
//   data       : synchronised copy of data_raw
//   state      : 0 IDLE, 1 START, 2 DATA, 3 STOP
//   tmr        : bit-period tick counter (0..BIT_TICKS-1)
//   uart_clk   : bit-rate square wave, high for the first half of each bit
//   uart_clk_2 : one-cycle strobe at the middle of each bit
module entry_rx
  import entry_pkg::*;
#(
  parameter int BIT_TICKS = 10,
  parameter int DATA_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_raw,
  output logic             data,
  output logic [1:0]       state,
  output logic [TMR_W-1:0] tmr,
  output logic             uart_clk,
  output logic             uart_clk_2
);

  localparam logic [TMR_W-1:0]  TMR_ZERO  = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0]  TMR_END   = TMR_W'(BIT_TICKS - 1);
  localparam logic [TMR_W-1:0]  TMR_MID   = TMR_W'(BIT_TICKS / 2 - 1);
  localparam logic [TMR_W-1:0]  TMR_HALF  = TMR_W'(BIT_TICKS / 2);
  localparam logic [BCNT_W-1:0] BCNT_ZERO = {BCNT_W{1'b0}};
  localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);

  logic              data_s;
  logic              prev_r;
  logic              fall_s;
  logic              bit_end_s;
  logic              mid_s;
  state_t            state_r;
  state_t            state_nxt_s;
  logic [TMR_W-1:0]  tmr_r;
  logic [TMR_W-1:0]  tmr_nxt_s;
  logic [TMR_W-1:0]  tmr_inc_s;
  logic [BCNT_W-1:0] bcnt_r;
  logic [BCNT_W-1:0] bcnt_nxt_s;
  logic              uart_clk_r;
  logic              uart_clk_2_r;

  // Idle level is 1, so reset to 1 to avoid a spurious edge out of reset.
  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (data_raw),
    .q   (data_s)
  );

  assign fall_s    = prev_r & ~data_s;
  assign bit_end_s = (tmr_r == TMR_END);
  assign mid_s     = (tmr_r == TMR_MID);
  assign tmr_inc_s = bit_end_s ? TMR_ZERO : (tmr_r + TMR_ONE);

  // Edge-detect history, FSM state, timer and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_r  <= 1'b1;
      state_r <= IDLE;
      tmr_r   <= TMR_ZERO;
      bcnt_r  <= BCNT_ZERO;
    end else begin
      prev_r  <= data_s;
      state_r <= state_nxt_s;
      tmr_r   <= tmr_nxt_s;
      bcnt_r  <= bcnt_nxt_s;
    end
  end

  // Next-state, timer and bit-counter decode.
  always_comb begin
    state_nxt_s = state_r;
    tmr_nxt_s   = tmr_r;
    bcnt_nxt_s  = bcnt_r;
    case (state_r)
      IDLE: begin
        tmr_nxt_s = TMR_ZERO;
        if (fall_s) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        // A line back high at mid start bit was noise, not a frame.
        if (mid_s && data_s) begin
          state_nxt_s = IDLE;
          tmr_nxt_s   = TMR_ZERO;
        end else if (bit_end_s) begin
          state_nxt_s = DATA;
          tmr_nxt_s   = TMR_ZERO;
          bcnt_nxt_s  = BCNT_ZERO;
        end else begin
          tmr_nxt_s   = tmr_inc_s;
        end
      end
      DATA: begin
        tmr_nxt_s = tmr_inc_s;
        if (bit_end_s) begin
          bcnt_nxt_s = bcnt_r + BCNT_ONE;
          if (bcnt_r == BCNT_LAST) begin
            state_nxt_s = STOP;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      STOP: begin
        // Stop-bit level is not checked; falling edges here are ignored.
        if (bit_end_s) begin
          state_nxt_s = IDLE;
          tmr_nxt_s   = TMR_ZERO;
        end else begin
          tmr_nxt_s   = tmr_inc_s;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        tmr_nxt_s   = TMR_ZERO;
        bcnt_nxt_s  = BCNT_ZERO;
      end
    endcase
  end

  // Strobes computed from next-state values so they align with state/tmr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_clk_r   <= 1'b0;
      uart_clk_2_r <= 1'b0;
    end else begin
      uart_clk_r   <= (state_nxt_s != IDLE) && (tmr_nxt_s < TMR_HALF);
      uart_clk_2_r <= (state_nxt_s != IDLE) && (tmr_nxt_s == TMR_MID);
    end
  end

  assign data       = data_s;
  assign state      = state_r;
  assign tmr        = tmr_r;
  assign uart_clk   = uart_clk_r;
  assign uart_clk_2 = uart_clk_2_r;

endmodule

// File: tb/tb_entry_rx.sv
// Scoreboard bench for entry_rx. The driver advances a frame-position model
// each cycle and queues the expected outputs; the monitor pops and compares.
module tb_entry_rx;

  localparam int BT    = 10;
  localparam int DB    = 8;
  localparam int FRAME = (DB + 2) * BT;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_raw;
  logic       data;
  logic [1:0] state;
  logic [5:0] tmr;
  logic       uart_clk;
  logic       uart_clk_2;

  always #5 clk = ~clk;

  entry_rx #(.BIT_TICKS(BT), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_raw   (data_raw),
    .data       (data),
    .state      (state),
    .tmr        (tmr),
    .uart_clk   (uart_clk),
    .uart_clk_2 (uart_clk_2)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: synchroniser pipeline plus position within the frame.
  logic m_s1 = 1'b1;
  logic m_s2 = 1'b1;
  logic m_prev = 1'b1;
  logic m_active = 1'b0;
  int   m_pos = 0;
  logic [10:0] sb_q[$];

  function automatic logic [10:0] m_out();
    int t;
    logic [1:0] st;
    logic [5:0] t6;
    t  = m_active ? (m_pos % BT) : 0;
    t6 = 6'(t);
    if (!m_active)             st = 2'd0;
    else if (m_pos < BT)       st = 2'd1;
    else if (m_pos < BT*(DB+1)) st = 2'd2;
    else                       st = 2'd3;
    return {m_s2, st, t6, (m_active && t < BT/2), (m_active && t == BT/2 - 1)};
  endfunction

  task automatic drive(input logic v, input logic r);
    logic d_old;
    logic f_old;
    @(negedge clk);
    data_raw = v;
    rst      = r;
    if (r) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_prev = 1'b1; m_active = 1'b0; m_pos = 0;
    end else begin
      d_old = m_s2;
      f_old = m_prev & ~m_s2;
      if (!m_active) begin
        if (f_old) begin
          m_active = 1'b1;
          m_pos    = 0;
        end
      end else if (m_pos == BT/2 - 1 && d_old) begin
        m_active = 1'b0;
        m_pos    = 0;
      end else if (m_pos == FRAME - 1) begin
        m_active = 1'b0;
        m_pos    = 0;
      end else begin
        m_pos++;
      end
      m_prev = m_s2;
      m_s2   = m_s1;
      m_s1   = v;
    end
    sb_q.push_back(m_out());
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) drive(v, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    hold(1'b0, BT);
    for (int i = 0; i < DB; i++) hold(b[i], BT);
    hold(1'b1, BT);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor bookkeeping.
  int   cyc = 0;
  int   st_cnt[4];
  int   pulses = 0;
  int   last_pulse = -1;
  logic gap_en = 1'b0;
  logic [10:0] exp_v;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      chk("cycle", {5'd0, data, state, tmr, uart_clk, uart_clk_2}, {5'd0, exp_v});
    end
    st_cnt[state]++;
    if (uart_clk_2) begin
      pulses++;
      if (gap_en && last_pulse >= 0) chk("pulse_gap", 16'(cyc - last_pulse), 16'd10);
      last_pulse = cyc;
    end
  end

  task automatic clear_stats();
    foreach (st_cnt[i]) st_cnt[i] = 0;
    pulses     = 0;
    last_pulse = -1;
  endtask

  initial begin
    bit hit;
    rst      = 1'b1;
    data_raw = 1'b1;

    // Reset hold with idle line.
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1);
    hold(1'b1, 5);

    // Full frame 0x55.
    clear_stats();
    gap_en = 1'b1;
    send_byte(8'h55);
    hold(1'b1, 10);
    settle();
    gap_en = 1'b0;
    chk("start_len", 16'(st_cnt[1]), 16'd10);
    chk("data_len",  16'(st_cnt[2]), 16'd80);
    chk("stop_len",  16'(st_cnt[3]), 16'd10);
    chk("frame_pulses", 16'(pulses), 16'd10);

    // Glitch: three low cycles only.
    clear_stats();
    hold(1'b0, 3);
    hold(1'b1, 20);
    settle();
    chk("glitch_start_len", 16'(st_cnt[1]), 16'd5);
    chk("glitch_data_len",  16'(st_cnt[2]), 16'd0);
    chk("glitch_pulses",    16'(pulses),    16'd1);

    // Square wave on the line.
    for (int k = 0; k < 20; k++) hold((k % 2) == 1, BT);
    hold(1'b1, 120);

    // Asynchronous reset in the middle of a DATA bit (tmr = 6).
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      drive(1'b0, 1'b0);
      hit = m_active && (m_pos == BT + 6);
    end
    chk("reached_data_tmr6", {15'd0, hit}, 16'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_state", {14'd0, state}, 16'd0);
    chk("async_tmr",   {10'd0, tmr},   16'd0);
    chk("async_data",  {15'd0, data},  16'd1);
    chk("async_uclk",  {15'd0, uart_clk}, 16'd0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
    hold(1'b1, 5);
    send_byte(8'hA3);
    hold(1'b1, 20);

    // Line low across reset release, then held low forever.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
    clear_stats();
    hold(1'b0, 150);
    settle();
    chk("low_release_start", 16'(st_cnt[1]), 16'd10);
    chk("low_forever_frames", 16'(pulses), 16'd10);
    hold(1'b1, 10);

    settle();
    chk("sb_drain", 16'(sb_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
